seven_seg_scanner: RTL and testbench

Time-multiplexed driver for the four-digit common-anode seven-segment display. Takes four hex/BCD nibbles plus decimal points from the stopwatch datapath and produces the active-low `anode_out`, `seg_out` and `dp_out` patterns. Each digit is scanned in turn, and a short blanking interval at the start of every digit slot suppresses ghosting. Its `anode_out` feeds the blink gating stage, which sits between this block and the pins.

---
 rtl/seven_seg_scanner.sv | 122 ++++++++++++
 tb/tb_seven_seg_scanner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode seven-segment scanner with a per-slot
// blanking interval and a frame-aligned input snapshot.
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 25000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  anode_out,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLK  = CW'(BLANK_CYCLES);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } phase_t;

  logic [CW-1:0] slot_cnt;
  logic [1:0]    idx;
  logic [15:0]   snap;
  logic [3:0]    dp_snap;

  phase_t        phase;
  logic [3:0]    nib;
  logic [6:0]    font;
  logic [3:0]    anode_nx;
  logic [6:0]    seg_nx;
  logic          dp_nx;
  logic          wrap;

  assign wrap = (slot_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= '0;
      idx        <= '0;
      snap       <= '0;
      dp_snap    <= '0;
      anode_out  <= 4'hF;
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      slot_cnt   <= '0;
      idx        <= '0;
      anode_out  <= 4'hF;
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
    end else begin
      slot_cnt <= wrap ? '0 : slot_cnt + 1'b1;
      if (wrap)
        idx <= idx + 2'd1;
      // Capture only at frame start so a frame is never torn.
      if (slot_cnt == '0 && idx == 2'd0) begin
        snap    <= digits_in;
        dp_snap <= dp_in;
      end
      anode_out  <= anode_nx;
      seg_out    <= seg_nx;
      dp_out     <= dp_nx;
      digit_idx  <= idx;
      frame_tick <= wrap && (idx == 2'd3);
    end
  end

  always_comb begin
    phase = (slot_cnt < BLK) ? BLANK : DRIVE;
  end

  always_comb begin
    anode_nx = 4'hF;
    seg_nx   = 7'h7F;
    dp_nx    = 1'b1;
    nib      = snap[{idx, 2'b00} +: 4];
    unique case (phase)
      BLANK: begin
        anode_nx = 4'hF;
      end
      DRIVE: begin
        anode_nx = ~(4'b0001 << idx);
        seg_nx   = font;
        dp_nx    = ~dp_snap[idx];
      end
    endcase
  end

  always_comb begin
    font = 7'h7F;
    unique case (nib)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      4'hF: font = 7'h0E;
    endcase
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_seven_seg_scanner;

  localparam int R = 8;
  localparam int B = 2;
  localparam int F = 4 * R;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  anode_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  seven_seg_scanner #(
    .REFRESH_DIV (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .anode_out (anode_out),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  typedef struct {
    int         cyc;
    string      tag;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       tick;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  logic [6:0] font_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL %s missed cyc=%0d now=%0d", e.tag, e.cyc, cyc);
      end else if (anode_out !== e.anode || seg_out !== e.seg ||
                   dp_out !== e.dp || digit_idx !== e.idx ||
                   frame_tick !== e.tick) begin
        bad++;
        $display("FAIL %s cyc=%0d got a=%b s=%h dp=%b i=%0d t=%b want a=%b s=%h dp=%b i=%0d t=%b",
                 e.tag, cyc, anode_out, seg_out, dp_out, digit_idx,
                 frame_tick, e.anode, e.seg, e.dp, e.idx, e.tick);
      end
    end
  end

  task automatic push_blank(input int c, input string tag);
    exp_t e;
    e.cyc = c; e.tag = tag;
    e.anode = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
    e.idx = 2'd0; e.tick = 1'b0;
    q.push_back(e);
  endtask

  // expected outputs for output cycles 1..nk of a frame
  task automatic expect_frame(input int start, input logic [15:0] dg,
                              input logic [3:0] dp, input int nk,
                              input string tag);
    for (int k = 1; k <= nk; k++) begin
      exp_t e;
      int s, d;
      logic [3:0] n;
      s = (k - 1) % R;
      d = (k - 1) / R;
      n = dg[d*4 +: 4];
      e.cyc = start + k - 1;
      e.tag = tag;
      e.idx = 2'(d);
      e.tick = (k == F);
      if (s < B) begin
        e.anode = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
        e.anode = 4'hF ^ (4'b0001 << d);
        e.seg = font_tab[n];
        e.dp = ~dp[d];
      end
      q.push_back(e);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    digits_in = 16'h1234;
    dp_in = 4'b0000;
    wait_neg(3);
    push_blank(cyc + 1, "reset");
    wait_neg(1);
    rst = 1'b0;
    expect_frame(cyc + 1, 16'h1234, 4'b0000, F, "basic");
    wait_neg(F);

    for (int n = 0; n < 16; n++) begin
      digits_in = {12'h987, 4'(n)};
      expect_frame(cyc + 1, digits_in, 4'b0000, F, "font");
      wait_neg(F);
    end

    digits_in = 16'h1234;
    expect_frame(cyc + 1, 16'h1234, 4'b0000, F, "tear_old");
    wait_neg(2 * R + 2);
    digits_in = 16'h5678;
    wait_neg(F - 2 * R - 2);
    expect_frame(cyc + 1, 16'h5678, 4'b0000, F, "tear_new");
    wait_neg(F);

    dp_in = 4'b0100;
    expect_frame(cyc + 1, 16'h5678, 4'b0100, F, "dp");
    wait_neg(F);
    dp_in = 4'b0000;

    expect_frame(cyc + 1, 16'h5678, 4'b0000, R + 4, "pre_en");
    wait_neg(R + 4);
    enable = 1'b0;
    for (int i = 1; i <= 5; i++)
      push_blank(cyc + i, "en_low");
    wait_neg(5);
    enable = 1'b1;
    digits_in = 16'hABCD;
    expect_frame(cyc + 1, 16'hABCD, 4'b0000, F, "en_rise");
    wait_neg(F);

    digits_in = 16'h0F3E;
    expect_frame(cyc + 1, 16'h0F3E, 4'b0000, 3 * R + 4, "pre_rst");
    wait_neg(3 * R + 4);
    rst = 1'b1;
    push_blank(cyc + 1, "rst_pulse");
    wait_neg(1);
    rst = 1'b0;
    digits_in = 16'h2468;
    expect_frame(cyc + 1, 16'h2468, 4'b0000, F, "post_rst");
    wait_neg(F);

    for (int i = 0; i < 100 && q.size() > 0; i++)
      wait_neg(1);
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
